// File: rtl/arith_pkg.sv
// arith_pkg: types and defaults shared by the sequential subtractor slice.
//   state_t   : FSM state encoding (IDLE, CALC, DONE)
//   DEF_N     : default operand/result width
//   DEF_CHUNK : default bits processed per CALC cycle
//   idx_width : chunk index counter width, never below 1 bit
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_N     = 64;
    localparam int unsigned DEF_CHUNK = 16;

    function automatic int unsigned idx_width(input int unsigned chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/seq_subtractor_sub_chunk.sv
// sub_chunk: combinational W-bit subtract with borrow in/out.
//   i_a, i_b : W-bit minuend / subtrahend slices
//   i_bin    : borrow from the next-lower chunk
//   o_diff   : W-bit difference i_a - i_b - i_bin (modulo 2^W)
//   o_bout   : borrow out of this chunk
module sub_chunk #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_bin,
    output logic [W-1:0] o_diff,
    output logic         o_bout
);

    logic [W:0] w_full;

    // One extra bit: a negative result leaves the top bit set, which is the borrow.
    assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{W{1'b0}}, i_bin};
    assign o_diff = w_full[W-1:0];
    assign o_bout = w_full[W];

endmodule

// File: rtl/seq_subtractor.sv
// seq_subtractor: multi-cycle unsigned N-bit subtractor, CHUNK bits per cycle,
// LSB chunk first, with a valid/ready handshake on both sides.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready high only in IDLE)
//   a, b                : minuend, subtrahend
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   diff, bout          : a - b modulo 2^N, borrow out (a < b)
// Build option: define SEQ_SUB_SATURATE_EN to present diff = 0 on underflow
// (bout still reports the borrow); otherwise the wrapped result is presented.
module seq_subtractor
    import arith_pkg::*;
#(
    parameter int unsigned N     = DEF_N,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout
);

    localparam int unsigned    NCHUNK   = N / CHUNK;
    localparam int unsigned    IDXW     = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (N % CHUNK != 0) begin : g_bad_chunk
        $error("seq_subtractor: N must be a multiple of CHUNK");
    end

    state_t                        r_state;
    logic [NCHUNK-1:0][CHUNK-1:0]  r_a;
    logic [NCHUNK-1:0][CHUNK-1:0]  r_b;
    logic [NCHUNK-1:0][CHUNK-1:0]  r_diff;
    logic                          r_borrow;
    logic                          r_bout;
    logic [IDXW-1:0]               r_idx;
    logic                          r_in_ready;
    logic                          r_out_valid;

    logic [CHUNK-1:0]              w_a_k;
    logic [CHUNK-1:0]              w_b_k;
    logic [CHUNK-1:0]              w_d_k;
    logic                          w_borrow_k;

    // Operands stay intact; the chunk index selects the slice being worked on.
    assign w_a_k = r_a[r_idx];
    assign w_b_k = r_b[r_idx];

    sub_chunk #(.W(CHUNK)) u_sub_chunk (
        .i_a    (w_a_k),
        .i_b    (w_b_k),
        .i_bin  (r_borrow),
        .o_diff (w_d_k),
        .o_bout (w_borrow_k)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_bout      <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_borrow   <= 1'b0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    r_diff[r_idx] <= w_d_k;
                    r_borrow      <= w_borrow_k;
                    if (r_idx == LAST_IDX) begin
                        r_bout      <= w_borrow_k;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
`ifdef SEQ_SUB_SATURATE_EN
                        // Final borrow means underflow: the whole result clamps to zero.
                        if (w_borrow_k) begin
                            r_diff <= '0;
                        end
`endif
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;

endmodule

// File: tb/tb_seq_subtractor.sv
// tb_seq_subtractor: directed vector table, handshake/reset corner sequences
// and randomized operands checked against an arithmetic reference model.
// Honours SEQ_SUB_SATURATE_EN in the same way as the design build.
module tb_seq_subtractor;

    localparam int unsigned N      = 64;
    localparam int unsigned CHUNK  = 16;
    localparam int unsigned NCHUNK = N / CHUNK;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         bout;

    int n_checks = 0;
    int n_fail   = 0;

    seq_subtractor #(.N(N), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] d;   // wrapped difference
        logic         bo;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference: two's complement subtraction plus unsigned compare.
    function automatic logic [N-1:0] model_diff(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N-1:0] w;
        w = x + ~y + 1'b1;
`ifdef SEQ_SUB_SATURATE_EN
        if (x < y) w = '0;
`endif
        return w;
    endfunction

    function automatic logic [N-1:0] presented(input logic [N-1:0] d, input logic bo);
`ifdef SEQ_SUB_SATURATE_EN
        if (bo) return '0;
`endif
        return d;
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns #1 after the
    // edge that completes the output handshake.
    task automatic run_op(input logic [N-1:0] xa, input logic [N-1:0] xb,
                          output logic [N-1:0] d_o, output logic bo_o, output int lat);
        a = xa; b = xb; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < int'(4 * NCHUNK + 8)) begin
            @(posedge clk); #1;
            lat++;
        end
        d_o = diff; bo_o = bout;
        if (!out_valid) begin
            n_checks++; n_fail++;
            $display("FAIL result_timeout: out_valid still 0 after %0d cycles, expected 1", lat);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [N-1:0] r_d, ha, hb, hd, ra, rb;
    logic         r_bo, hbo;
    int           lat, mode;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{64'd5, 64'd3, 64'd2, 1'b0};
        tbl[1] = '{64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        tbl[2] = '{64'h0000_0000_0001_0000, 64'd1, 64'h0000_0000_0000_FFFF, 1'b0};
        tbl[3] = '{64'd7, 64'd7, 64'd0, 1'b0};
        tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[5] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1};
        tbl[6] = '{64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[7] = '{64'h0001_0000_0000_0000, 64'd1, 64'h0000_FFFF_FFFF_FFFF, 1'b0};
        tbl[8] = '{64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        tbl[9] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h0246_8ACF_1357_9BCF, 1'b0};

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_diff", diff, 64'd0);
        check("rst_bout", 64'(bout), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed vectors
        foreach (tbl[i]) begin
            run_op(tbl[i].a, tbl[i].b, r_d, r_bo, lat);
            check($sformatf("vec%0d_diff", i), r_d, presented(tbl[i].d, tbl[i].bo));
            check($sformatf("vec%0d_bout", i), 64'(r_bo), 64'(tbl[i].bo));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(NCHUNK));
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'd1);
        end

        // Back-pressure: result held in DONE, new operands ignored
        ha = 64'h0123_4567_89AB_CDEF; hb = 64'hFEDC_BA98_7654_3210;
        hd = model_diff(ha, hb); hbo = (ha < hb);
        a = ha; b = hb; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (NCHUNK) @(posedge clk);
        #1;
        check("hold_enter_valid", 64'(out_valid), 64'd1);
        for (int c = 0; c < 5; c++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; in_valid = 1'b1;
            @(posedge clk); #1;
            check($sformatf("hold%0d_valid", c), 64'(out_valid), 64'd1);
            check($sformatf("hold%0d_diff", c), diff, hd);
            check($sformatf("hold%0d_bout", c), 64'(bout), 64'(hbo));
            check($sformatf("hold%0d_in_ready", c), 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold_release_valid", 64'(out_valid), 64'd0);
        check("hold_release_in_ready", 64'(in_ready), 64'd1);

        // Reset while chunk 2 is pending
        a = 64'hFFFF_0000_FFFF_0000; b = 64'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_diff", diff, 64'd0);
        check("midrst_bout", 64'(bout), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check($sformatf("midrst_quiet%0d", c), 64'(out_valid), 64'd0);
        end
        run_op(64'd7, 64'd7, r_d, r_bo, lat);
        check("after_rst_diff", r_d, 64'd0);
        check("after_rst_bout", 64'(r_bo), 64'd0);
        check("after_rst_latency", 64'(lat), 64'(NCHUNK));

        // Randomized operands
        for (int i = 0; i < 10000; i++) begin
            mode = int'($urandom_range(0, 3));
            rb = {$urandom, $urandom};
            case (mode)
                0: ra = {$urandom, $urandom};
                1: ra = rb;
                2: ra = rb + 64'($urandom_range(0, 3)) - 64'd1;
                default: begin
                    ra = 64'($urandom_range(0, 255)) << (16 * $urandom_range(0, 3));
                    rb = 64'($urandom_range(0, 255)) << (16 * $urandom_range(0, 3));
                end
            endcase
            run_op(ra, rb, r_d, r_bo, lat);
            check($sformatf("rand%0d_diff", i), r_d, model_diff(ra, rb));
            check($sformatf("rand%0d_bout", i), 64'(r_bo), 64'(ra < rb));
            check($sformatf("rand%0d_latency", i), 64'(lat), 64'(NCHUNK));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_subtractor.md
SEQ_SUBTRACTOR -- requirements
Module: seq_subtractor

Interface
REQ-001 SHALL have parameter N, default 64: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 16: bits processed per CALC cycle.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: operands a and b are valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have port a, input, N: minuend.
REQ-008 SHALL have port b, input, N: subtrahend.
REQ-009 SHALL have port out_valid, output, 1: diff and bout are valid.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port diff, output, N: the result a - b, modulo 2^N.
REQ-012 SHALL have port bout, output, 1: borrow out, set when a < b (unsigned).

Function
REQ-013 SHALL implement an FSM with three states: IDLE, CALC and DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE.
REQ-015 SHALL, in IDLE, register a and b when in_valid && in_ready, clear the borrow and chunk index, and go to CALC.
REQ-016 SHALL, on each CALC edge for chunk k (LSB first), compute {borrow, diff[k*CHUNK +: CHUNK]} = a_k - b_k - borrow.
REQ-017 SHALL enter DONE after exactly N/CHUNK CALC edges, which gives a latency of N/CHUNK cycles from the accept edge to out_valid high.
REQ-018 SHALL hold diff, bout and out_valid stable in DONE while out_ready = 0.
REQ-019 SHALL return to IDLE on out_valid && out_ready; in_ready rises in the following cycle, with no back-to-back accept in the same cycle.
REQ-020 SHALL set bout to the final borrow out of the MSB chunk.
REQ-021 SHALL ignore in_valid in CALC and DONE, and SHALL NOT modify the registered operands there.
REQ-022 SHALL treat CHUNK = N as a legal single-CALC-cycle configuration.
REQ-023 SHALL require N % CHUNK == 0, checked by an elaboration-time assertion or error.
REQ-024 SHALL treat operands as unsigned and SHALL NOT produce an overflow flag.

Reset
REQ-025 SHALL, while rst_n = 0, force state to IDLE and force diff = 0, bout = 0, out_valid = 0, chunk index = 0 and borrow = 0.
REQ-026 SHALL drive in_ready = 1 in the first cycle after rst_n deasserts.
REQ-027 SHALL, on reset asserted mid-CALC or in DONE, abort the operation with no output handshake and discard the result.

Configuration
REQ-028 SHALL use macro SEQ_SUB_SATURATE_EN to select the underflow behaviour.
REQ-029 SHALL, when SEQ_SUB_SATURATE_EN is defined and the final borrow = 1, present diff = 0 in DONE; bout is still 1.
REQ-030 SHALL, when SEQ_SUB_SATURATE_EN is undefined, present the wrapped modulo-2^N result.

Structure
REQ-031 SHALL place the FSM state enum (IDLE, CALC, DONE) and the default N/CHUNK localparams in shared package arith_pkg.
REQ-032 SHALL instantiate one combinational sub-module, sub_chunk (CHUNK-wide a - b - bin giving diff and bout), once.
REQ-033 SHALL make the chunk index counter width $clog2(N/CHUNK), with a minimum of 1 bit.

Verification
REQ-034 SHALL cover this case (N=64, CHUNK=16): a=5, b=3 accepted at edge 0 -> out_valid high after edge 4, diff=2, bout=0.
REQ-035 SHALL cover this case: a=0, b=1 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1 (macro undefined); diff=0, bout=1 (SEQ_SUB_SATURATE_EN defined).
REQ-036 SHALL cover this case: a=0x0000_0000_0001_0000, b=1 -> diff=0x0000_0000_0000_FFFF, bout=0 (borrow crosses a chunk boundary).
REQ-037 SHALL cover this case: out_ready held 0 for 5 cycles in DONE -> diff and bout stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-038 SHALL cover this case: rst_n pulsed low during CALC chunk 2 -> out_valid stays 0, outputs reset to 0, in_ready=1 after release; a fresh 7-7 gives diff=0, bout=0.
REQ-039 SHALL cover this case: random 10k operand pairs, compared against a + (~b) + 1 in the model -> diff matches and bout = (a < b), checked in both macro settings.
